// File: rtl/anc_tap_sched.sv
// Per-sample sequencer for the filtered-x LMS datapath: runs FIR, FXN and LMS passes over TAPS taps,
// driving circular RAM addresses, MAC control, write strobes and frame strobes.
module anc_tap_sched #(
  parameter int TAPS   = 126,
  parameter int AW     = 7,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          sample_stb_i,
  output logic          busy_o,
  output logic [1:0]    phase_o,
  output logic [AW-1:0] coef_addr_o,
  output logic [AW-1:0] hist_addr_o,
  output logic [AW-1:0] wr_ptr_o,
  output logic          xn_wren_o,
  output logic          acc_clr_o,
  output logic          acc_en_o,
  output logic          y_stb_o,
  output logic          sn_wren_o,
  output logic          wz_wren_o,
  output logic [AW-1:0] wz_waddr_o,
  output logic          done_o,
  output logic [7:0]    ovr_cnt_o
);

  localparam int LAST = TAPS + RD_LAT;
  localparam int CW   = $clog2(LAST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FIR = 2'd1, FXN = 2'd2, LMS = 2'd3} phase_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  phase_t        phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] coef_q, coef_d;
  logic [AW-1:0] hist_q, hist_d;
  logic [7:0]    ovr_q, ovr_d;
  logic          issue_q, issue_d;
  logic          busy_q, busy_d;
  logic          xn_wren_q, xn_wren_d;
  logic          y_stb_q, y_stb_d;
  logic          sn_wren_q, sn_wren_d;
  logic          done_q, done_d;
  logic          start, last;

  logic [RD_LAT-1:0] iss_dly_q;
  logic [RD_LAT-1:0] clr_dly_q;
  logic [RD_LAT-1:0] lms_dly_q;
  logic [AW-1:0]     waddr_dly_q [RD_LAT];

  assign start = (phase_q == IDLE) && sample_stb_i && en_i;
  assign last  = (phase_q != IDLE) && (cnt_q == CW'(LAST));

  // next-state: pass sequencing, write pointer, overrun counter
  always_comb begin
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    ovr_d    = ovr_q;
    if (phase_q == IDLE) begin
      if (start) begin
        phase_d  = FIR;
        cnt_d    = '0;
        wr_ptr_d = (wr_ptr_q == AW'(TAPS - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
    end else if (last) begin
      cnt_d = '0;
      case (phase_q)
        FIR:     phase_d = FXN;
        FXN:     phase_d = LMS;
        default: phase_d = IDLE;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (sample_stb_i && en_i && (phase_q != IDLE)) ovr_d = sat_inc(ovr_q);
  end

  // registered-output next values, derived from the next state
  always_comb begin
    busy_d    = (phase_d != IDLE);
    issue_d   = busy_d && (cnt_d < CW'(TAPS));
    coef_d    = issue_d ? AW'(cnt_d) : '0;
    hist_d    = wr_ptr_d;
    if (issue_d && (cnt_d != '0))
      hist_d = (hist_q == '0) ? AW'(TAPS - 1) : hist_q - AW'(1);
    xn_wren_d = start;
    y_stb_d   = (phase_d == FIR) && (cnt_d == CW'(LAST));
    sn_wren_d = (phase_d == FXN) && (cnt_d == CW'(LAST));
    done_d    = (phase_q == LMS) && last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q   <= IDLE;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      ovr_q     <= '0;
      coef_q    <= '0;
      hist_q    <= '0;
      issue_q   <= 1'b0;
      busy_q    <= 1'b0;
      xn_wren_q <= 1'b0;
      y_stb_q   <= 1'b0;
      sn_wren_q <= 1'b0;
      done_q    <= 1'b0;
      iss_dly_q <= '0;
      clr_dly_q <= '0;
      lms_dly_q <= '0;
      for (int i = 0; i < RD_LAT; i++) waddr_dly_q[i] <= '0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      ovr_q     <= ovr_d;
      coef_q    <= coef_d;
      hist_q    <= hist_d;
      issue_q   <= issue_d;
      busy_q    <= busy_d;
      xn_wren_q <= xn_wren_d;
      y_stb_q   <= y_stb_d;
      sn_wren_q <= sn_wren_d;
      done_q    <= done_d;
      // read-latency alignment: operands arrive RD_LAT cycles after the address
      iss_dly_q[0]   <= issue_q;
      clr_dly_q[0]   <= issue_q && (coef_q == '0);
      lms_dly_q[0]   <= issue_q && (phase_q == LMS);
      waddr_dly_q[0] <= coef_q;
      for (int i = 1; i < RD_LAT; i++) begin
        iss_dly_q[i]   <= iss_dly_q[i-1];
        clr_dly_q[i]   <= clr_dly_q[i-1];
        lms_dly_q[i]   <= lms_dly_q[i-1];
        waddr_dly_q[i] <= waddr_dly_q[i-1];
      end
    end
  end

  assign busy_o      = busy_q;
  assign phase_o     = phase_q;
  assign coef_addr_o = coef_q;
  assign hist_addr_o = hist_q;
  assign wr_ptr_o    = wr_ptr_q;
  assign xn_wren_o   = xn_wren_q;
  assign acc_en_o    = iss_dly_q[RD_LAT-1];
  assign acc_clr_o   = clr_dly_q[RD_LAT-1];
  assign y_stb_o     = y_stb_q;
  assign sn_wren_o   = sn_wren_q;
  assign wz_wren_o   = lms_dly_q[RD_LAT-1];
  assign wz_waddr_o  = waddr_dly_q[RD_LAT-1];
  assign done_o      = done_q;
  assign ovr_cnt_o   = ovr_q;

endmodule

// File: tb/tb_anc_tap_sched.sv
// Bench for anc_tap_sched: two instances (TAPS=4/RD_LAT=1 and TAPS=126/RD_LAT=2) checked every cycle
// against a frame-time model, plus literal expectations for the documented scenarios.
module tb_anc_tap_sched;

  localparam int TA = 4,   LA = 1, AWA = 2;
  localparam int TB = 126, LB = 2, AWB = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, stb;

  logic           busy_a, xn_wren_a, acc_clr_a, acc_en_a, y_stb_a, sn_wren_a, wz_wren_a, done_a;
  logic [1:0]     phase_a;
  logic [AWA-1:0] coef_a, hist_a, wrp_a, wza_a;
  logic [7:0]     ovr_a;

  logic           busy_b, xn_wren_b, acc_clr_b, acc_en_b, y_stb_b, sn_wren_b, wz_wren_b, done_b;
  logic [1:0]     phase_b;
  logic [AWB-1:0] coef_b, hist_b, wrp_b, wza_b;
  logic [7:0]     ovr_b;

  anc_tap_sched #(.TAPS(TA), .AW(AWA), .RD_LAT(LA)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sample_stb_i(stb),
    .busy_o(busy_a), .phase_o(phase_a), .coef_addr_o(coef_a), .hist_addr_o(hist_a),
    .wr_ptr_o(wrp_a), .xn_wren_o(xn_wren_a), .acc_clr_o(acc_clr_a), .acc_en_o(acc_en_a),
    .y_stb_o(y_stb_a), .sn_wren_o(sn_wren_a), .wz_wren_o(wz_wren_a), .wz_waddr_o(wza_a),
    .done_o(done_a), .ovr_cnt_o(ovr_a)
  );

  anc_tap_sched #(.TAPS(TB), .AW(AWB), .RD_LAT(LB)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sample_stb_i(stb),
    .busy_o(busy_b), .phase_o(phase_b), .coef_addr_o(coef_b), .hist_addr_o(hist_b),
    .wr_ptr_o(wrp_b), .xn_wren_o(xn_wren_b), .acc_clr_o(acc_clr_b), .acc_en_o(acc_en_b),
    .y_stb_o(y_stb_b), .sn_wren_o(sn_wren_b), .wz_wren_o(wz_wren_b), .wz_waddr_o(wza_b),
    .done_o(done_b), .ovr_cnt_o(ovr_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: t = cycles since the frame's first busy cycle (large = idle, no done pending)
  localparam int IDLE_T = 1000000;
  int  tA = IDLE_T, wpA = 0, ovA = 0;
  int  tB = IDLE_T, wpB = 0, ovB = 0;
  bit  chk_on = 1'b0;

  task automatic mstep(input int taps, input int lat, inout int t, inout int wp, inout int ov);
    int L;
    bit pb;
    L  = taps + lat + 1;
    pb = (t < 3 * L);
    if (rst) begin
      t = IDLE_T; wp = 0; ov = 0;
    end else if (stb && en && !pb) begin
      t  = 0;
      wp = (wp + 1) % taps;
    end else begin
      if (stb && en && pb && ov < 255) ov++;
      if (t < IDLE_T) t++;
    end
  endtask

  always @(posedge clk) begin
    mstep(TA, LA, tA, wpA, ovA);
    mstep(TB, LB, tB, wpB, ovB);
    if (rst) chk_on <= 1'b1;
  end

  task automatic cmp(input string p, input int taps, input int lat, input int t, input int wp,
                     input int ov, input logic [31:0] busy, input logic [31:0] phase,
                     input logic [31:0] coef, input logic [31:0] hist, input logic [31:0] wrp,
                     input logic [31:0] xnw, input logic [31:0] aclr, input logic [31:0] aen,
                     input logic [31:0] ys, input logic [31:0] snw, input logic [31:0] wzw,
                     input logic [31:0] wza, input logic [31:0] dn, input logic [31:0] ovc);
    int L, k, ps;
    bit b, iss, ae;
    L   = taps + lat + 1;
    b   = (t < 3 * L);
    k   = t % L;
    ps  = t / L;
    iss = b && (k < taps);
    ae  = b && (k >= lat) && (k < taps + lat);
    chk({p, ".busy"},     busy, int'(b));
    chk({p, ".phase"},    phase, b ? ps + 1 : 0);
    chk({p, ".coef"},     coef, iss ? k : 0);
    chk({p, ".hist"},     hist, iss ? (wp - k + taps) % taps : wp);
    chk({p, ".wr_ptr"},   wrp, wp);
    chk({p, ".xn_wren"},  xnw, int'(t == 0));
    chk({p, ".acc_clr"},  aclr, int'(ae && k == lat));
    chk({p, ".acc_en"},   aen, int'(ae));
    chk({p, ".y_stb"},    ys, int'(b && ps == 0 && k == L - 1));
    chk({p, ".sn_wren"},  snw, int'(b && ps == 1 && k == L - 1));
    chk({p, ".wz_wren"},  wzw, int'(ae && ps == 2));
    chk({p, ".wz_waddr"}, wza, ae ? k - lat : 0);
    chk({p, ".done"},     dn, int'(t == 3 * L));
    chk({p, ".ovr_cnt"},  ovc, ov);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("A", TA, LA, tA, wpA, ovA, busy_a, phase_a, coef_a, hist_a, wrp_a, xn_wren_a,
          acc_clr_a, acc_en_a, y_stb_a, sn_wren_a, wz_wren_a, wza_a, done_a, ovr_a);
      cmp("B", TB, LB, tB, wpB, ovB, busy_b, phase_b, coef_b, hist_b, wrp_b, xn_wren_b,
          acc_clr_b, acc_en_b, y_stb_b, sn_wren_b, wz_wren_b, wza_b, done_b, ovr_b);
    end
  end

  task automatic wait_done_a(input string nm);
    int w;
    w = 0;
    while (!done_a && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk(nm, done_a, 1);
  endtask

  task automatic wait_idle_a(input string nm);
    int w;
    w = 0;
    while (busy_a && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk(nm, busy_a, 0);
  endtask

  task automatic frame_a(input string nm);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    wait_done_a(nm);
  endtask

  initial begin
    int eh[4] = '{1, 0, 3, 2};
    int nbusy, nys, ndn, bcnt, bwz, dcyc;
    bit bdone;

    rst = 1'b1; en = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.busy", busy_a, 0);
    chk("reset.phase", phase_a, 0);
    chk("reset.wr_ptr", wrp_a, 0);
    chk("reset.ovr_cnt", ovr_a, 0);

    // reference frame: stb in c0, A checked cycle by cycle, B measured to completion
    rst = 1'b0; en = 1'b1; stb = 1'b1;
    nbusy = 0; nys = 0; bcnt = 0; bwz = 0; bdone = 1'b0;
    for (int j = 1; j <= 400; j++) begin
      @(negedge clk);
      stb = 1'b0;
      if (j <= 20) begin
        nbusy += int'(busy_a);
        nys   += int'(y_stb_a);
      end
      if (j == 1) begin
        chk("c1.wr_ptr", wrp_a, 1);
        chk("c1.xn_wren", xn_wren_a, 1);
      end
      if (j >= 1 && j <= 4) begin
        chk("fir.coef", coef_a, j - 1);
        chk("fir.hist", hist_a, eh[j-1]);
      end
      if (j == 6)  chk("c6.y_stb", y_stb_a, 1);
      if (j == 12) chk("c12.sn_wren", sn_wren_a, 1);
      if (j == 18) chk("c18.busy", busy_a, 1);
      if (j == 19) begin
        chk("c19.done", done_a, 1);
        chk("c19.busy", busy_a, 0);
      end
      bcnt += int'(busy_b);
      bwz  += int'(wz_wren_b);
      if (done_b) bdone = 1'b1;
    end
    chk("A.busy_len", nbusy, 18);
    chk("A.y_stb_count", nys, 1);
    chk("B.done_seen", bdone, 1);
    chk("B.busy_len", bcnt, 387);
    chk("B.wz_wren_count", bwz, 126);

    // pointer wrap after four frames
    for (int f = 0; f < 3; f++) frame_a("wrap.frame_done");
    chk("wrap.wr_ptr", wrp_a, 0);
    stb = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      stb = 1'b0;
      chk("wrap.hist", hist_a, eh[j-1]);
    end
    wait_done_a("wrap.last_done");

    // single overrun mid-FXN
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (8) @(negedge clk);
    chk("ovr.phase_fxn", phase_a, 2);
    chk("ovr.before", ovr_a, 0);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    chk("ovr.after", ovr_a, 1);
    nys = 0; ndn = 0;
    for (int j = 0; j < 40 && ndn == 0; j++) begin
      nys += int'(y_stb_a);
      ndn += int'(done_a);
      if (ndn == 0) @(negedge clk);
    end
    chk("ovr.extra_y_stb", nys, 0);
    chk("ovr.done_count", ndn, 1);

    // sustained overruns saturate
    stb = 1'b1;
    repeat (420) @(negedge clk);
    stb = 1'b0;
    chk("ovr.saturated", ovr_a, 255);
    wait_idle_a("ovr.idle");

    // reset in the middle of LMS
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    repeat (14) @(negedge clk);
    chk("rstmid.phase_lms", phase_a, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.phase", phase_a, 0);
    chk("rstmid.busy", busy_a, 0);
    chk("rstmid.wz_wren", wz_wren_a, 0);
    chk("rstmid.wr_ptr", wrp_a, 0);
    ndn = 0;
    repeat (10) begin
      @(negedge clk);
      ndn += int'(done_a);
    end
    chk("rstmid.no_done", ndn, 0);

    // en dropped mid-frame: frame completes, later sample ignored without overrun
    en = 1'b1; stb = 1'b1;
    dcyc = 0;
    @(negedge clk);
    stb = 1'b0;
    dcyc = 1;
    repeat (4) begin
      @(negedge clk);
      dcyc++;
    end
    en = 1'b0;
    while (!done_a && dcyc < 60) begin
      @(negedge clk);
      dcyc++;
    end
    chk("enlow.done_cycle", dcyc, 19);
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    chk("enlow.no_frame", busy_a, 0);
    chk("enlow.ovr_cnt", ovr_a, 0);

    // randomized traffic
    for (int j = 0; j < 4000; j++) begin
      @(negedge clk);
      stb = ($urandom_range(0, 7) == 0);
      en  = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 599) == 0);
    end
    rst = 1'b0; stb = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
